mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers, driven by main-decoder
//  controls (multordiv, hlwrite, mvhl). Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles.
//  Sits beside the EX-stage ALU; raises stall so the pipeline freezes on HI/LO hazards.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are WIDTH bits each; must be >= 4 and even
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  start      in   1      launch op (decoder hlwrite & EX valid); ignored while busy
//  multordiv  in   1      1 = multiply, 0 = divide
//  is_signed  in   1      1 = two's-complement operands, 0 = unsigned
//  a          in   WIDTH  multiplicand / dividend (rs)
//  b          in   WIDTH  multiplier / divisor (rt)
//  mvhl       in   2      2'b10 read HI (MFHI), 2'b01 read LO (MFLO), 2'b00 none
//  rdata      out  WIDTH  HI or LO per mvhl, 0 when mvhl=00; combinational from registers
//  busy       out  1      operation in flight
//  stall      out  1      busy & (start | mvhl!=00); freezes IF/ID/EX
//  done       out  1      one-cycle pulse: HI/LO just updated
//  dbz        out  1      sticky divide-by-zero flag of last op; cleared on next start
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, busy=stall=done=dbz=0, counter=0. Reset mid-op aborts;
//   no done pulse, HI/LO forced to 0.
//  FSM: IDLE -> RUN on start (edge E0; latches |a|,|b|, sign flags, op, dbz=(div & b==0)).
//   RUN: one iteration per cycle, counter WIDTH-1 downto 0; at counter==0 -> FIX.
//   FIX: sign correction, write HI/LO, done=1 next cycle, -> IDLE.
//  Latency: start at E0 -> HI/LO and done visible after E(WIDTH+1); busy high WIDTH+1
//   cycles; busy=0 in the done cycle, so a new start there is accepted (back-to-back).
//  start while busy: ignored (stall holds it; pipeline re-presents it after busy drops).
//  Multiply: radix-2 shift-add on 2*WIDTH accumulator of magnitudes; result negated
//   (2*WIDTH two's complement) iff is_signed & sign(a)!=sign(b). {HI,LO}=product.
//  Divide: restoring, WIDTH+1-bit partial remainder on magnitudes. LO=quotient,
//   HI=remainder. If signed: quotient negated iff signs differ; remainder takes sign of a.
//   -2^(W-1) / -1 -> LO=0x80..0, HI=0 (natural wrap, no trap).
//  Divide by zero: still runs full latency; result LO=all-ones, HI=a (unmodified); dbz=1.
//  Unsigned mode: magnitudes = raw operands; no sign fix; is_signed sampled at start only.
//  Operand inputs are sampled only at start; changes during RUN have no effect.
//  rdata during busy reflects old HI/LO; stall guarantees it is not consumed.
// STRUCTURE
//  Package mdu_pkg: typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FIX} mdu_state_t;
//   localparams MVHL_NONE=2'b00, MVHL_LO=2'b01, MVHL_HI=2'b10 (shared with maindec).
//  Single module; no sub-module. Counter width $clog2(WIDTH). One always_ff for FSM +
//   datapath, one always_comb for next-iteration add/subtract and rdata/stall.
// TESTING (WIDTH=32)
//  1 MULTU a=FFFFFFFF b=2 -> after 33 cycles HI=00000001 LO=FFFFFFFE, done one cycle.
//  2 MULT a=-3 b=7 -> HI=FFFFFFFF LO=FFFFFFEB; MFLO via mvhl=01 -> rdata=FFFFFFEB.
//  3 DIV a=-7 b=2 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU a=7 b=2 -> LO=3 HI=1.
//  4 DIV a=5 b=0 -> LO=FFFFFFFF HI=00000005 dbz=1; next valid start clears dbz.
//  5 mvhl=10 or start during RUN -> stall=1, HI/LO unchanged; second start ignored.
//  6 reset at cycle 10 of RUN -> next cycle busy=0, HI=LO=0, done never pulses.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The HI/LO read-select codes are also used by the main decoder.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  localparam logic [1:0] MVHL_NONE = 2'b00;
  localparam logic [1:0] MVHL_LO   = 2'b01;
  localparam logic [1:0] MVHL_HI   = 2'b10;

endpackage

// File: rtl/mdu_iter_if.sv
// Decoder/EX-side handshake bundle of the multiply/divide unit.
// The master drives the controls and operands; the slave is the MDU.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             multordiv;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mvhl;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic             dbz;

  modport master (
    output start, multordiv, is_signed, a, b, mvhl,
    input  rdata, busy, stall, done, dbz
  );

  modport slave (
    input  start, multordiv, is_signed, a, b, mvhl,
    output rdata, busy, stall, done, dbz
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
// An operation takes WIDTH iterations plus one sign-fix cycle; stall freezes the pipe on hazards.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mdu_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic               mul_q, mul_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    mul_d    = mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    sign_a = bus.is_signed & bus.a[WIDTH-1];
    sign_b = bus.is_signed & bus.b[WIDTH-1];
    mag_a  = sign_a ? -bus.a : bus.a;
    mag_b  = sign_b ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, op_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: remainder < divisor, so the shifted trial fits a signed WIDTH+1 difference.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_q};

    unique case (state_q)
      MDU_IDLE: begin
        if (bus.start) begin
          state_d  = MDU_RUN;
          cnt_d    = CW'(WIDTH - 1);
          mul_d    = bus.multordiv;
          op_d     = bus.multordiv ? mag_a : mag_b;
          acc_d    = {{WIDTH{1'b0}}, (bus.multordiv ? mag_b : mag_a)};
          rem_d    = '0;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          dbz_d    = !bus.multordiv && (bus.b == '0);
          busy_d   = 1'b1;
        end
      end
      MDU_RUN: begin
        if (mul_q) begin
          acc_d = mul_next;
        end else if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        if (mul_q) begin
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
        end else begin
          // With a zero divisor the remainder path naturally reproduces a; only LO is forced.
          lo_d = dbz_q ? {WIDTH{1'b1}} :
                 (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = neg_hi_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    bus.busy  = busy_q;
    bus.done  = done_q;
    bus.dbz   = dbz_q;
    bus.stall = busy_q & (bus.start | (bus.mvhl != MVHL_NONE));
    unique case (bus.mvhl)
      MVHL_HI: bus.rdata = hi_q;
      MVHL_LO: bus.rdata = lo_q;
      default: bus.rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      mul_q    <= mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus();

  mdu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {dbz, HI, LO} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_op(input bit mul, input bit sgn,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] prod;
    logic [W-1:0] hi, lo;
    if (mul) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        prod = p;
      end else begin
        prod = {32'b0, a} * {32'b0, b};
      end
      return {1'b0, prod};
    end
    if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
    return {1'b0, hi, lo};
  endfunction

  task automatic launch(input bit mul, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.multordiv = mul;
    bus.is_signed = sgn;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = ~sgn;
    bus.multordiv = ~mul;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 100);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    bus.mvhl = MVHL_HI; #1;
    hi = bus.rdata;
    bus.mvhl = MVHL_LO; #1;
    lo = bus.rdata;
    bus.mvhl = MVHL_NONE; #1;
  endtask

  task automatic do_op(input string tag, input bit mul, input bit sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input bit exp_dbz);
    logic [W-1:0] hi, lo;
    launch(mul, sgn, a, b);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(tag, W + 1);
    read_hilo(hi, lo);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_dbz"}, 64'(bus.dbz), 64'(exp_dbz));
    $display("op %-10s mul=%0d sgn=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d", tag, mul, sgn, a, b, hi, lo, bus.dbz);
  endtask

  initial begin
    logic [W-1:0] hi, lo, ra, rb;
    logic [64:0] exp;
    bit rm, rs, seen;

    bus.start = 1'b0;
    bus.multordiv = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mvhl = MVHL_NONE;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dbz", 64'(bus.dbz), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    read_hilo(hi, lo);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_rdata_none", 64'(bus.rdata), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("multu", 1, 0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);

    // Consecutive do_op calls launch in the done cycle: back-to-back acceptance.
    do_op("mult", 1, 1, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    do_op("div", 0, 1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_op("divu", 0, 0, 32'd7, 32'd2, 32'd1, 32'd3, 0);
    do_op("div_minm1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    do_op("mult_min", 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 0);
    do_op("div_by0", 0, 1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    do_op("div_neg0", 0, 1, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    do_op("divu_clr", 0, 0, 32'd9, 32'd4, 32'd1, 32'd2, 0);

    // Hazard: reads and a second start during RUN stall and leave HI/LO alone.
    launch(1, 0, 32'd6, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    bus.mvhl = MVHL_HI; #1;
    check("haz_stall_mfhi", 64'(bus.stall), 64'd1);
    check("haz_old_hi", 64'(bus.rdata), 64'd1);
    bus.mvhl = MVHL_NONE; #1;
    check("haz_no_stall", 64'(bus.stall), 64'd0);
    bus.multordiv = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd100; bus.b = 32'd100;
    bus.start = 1'b1; #1;
    check("haz_stall_start", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("haz", W + 1 - 4);
    read_hilo(hi, lo);
    check("haz_hi", 64'(hi), 64'd0);
    check("haz_lo", 64'(lo), 64'd42);
    $display("op %-10s mul=1 sgn=0 a=%h b=%h -> hi=%h lo=%h", "hazard", 32'd6, 32'd7, hi, lo);

    for (int i = 0; i < 24; i++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = (i % 5 == 2) ? 32'h8000_0000 : $urandom;
      rb = $urandom;
      if (i % 7 == 3) rb = '0;
      else if (i % 3 == 1) rb = 32'($urandom_range(1, 15));
      else if (i % 8 == 5) rb = 32'hFFFF_FFFF;
      exp = ref_op(rm, rs, ra, rb);
      do_op($sformatf("rnd%0d", i), rm, rs, ra, rb, exp[63:32], exp[31:0], exp[64]);
    end

    do_op("pre_rst", 1, 0, 32'd3, 32'd5, 32'd0, 32'd15, 0);
    launch(1, 1, 32'd12345, -32'sd678);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_dbz", 64'(bus.dbz), 64'd0);
    read_hilo(hi, lo);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    $display("op %-10s reset mid-run -> hi=%h lo=%h done_seen=%0d", "abort", hi, lo, seen);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
